data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter N, default 16, data and address width in bits.
REQ-002 Parameter STARVE_LIMIT, default 4, count of consecutive lost DMA cycles that forces a DMA grant.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req  in  1  MEM-stage access request (load or store).
REQ-007 cpu_write, cpu_byte_en  in  1 each  store strobe; byte-lane select.
REQ-008 cpu_addr, cpu_wdata  in  N each  CPU address; CPU store data.
REQ-009 cpu_rdata  out  N  combinational read data returned to the MEM stage.
REQ-010 cpu_stall  out  1  freezes the PC and all pipeline buffers this cycle.
REQ-011 dma_req, dma_write, dma_byte_en  in  1 each  loader/DMA request, store strobe, byte select.
REQ-012 dma_addr, dma_wdata  in  N each  DMA address; DMA store data.
REQ-013 dma_ack  out  1  one-cycle completion pulse.
REQ-014 dma_rdata  out  N  registered read data, valid while dma_ack=1.
REQ-015 mem_write, mem_byte_en  out  1 each  data memory controls.
REQ-016 mem_address, mem_write_data  out  N each  to data memory.
REQ-017 mem_read_data  in  N  asynchronous read data from data memory.
REQ-018 grant_dma  out  1  high in any cycle in which the DMA owns the memory.

Function
REQ-019 A DMA request SHALL be eligible only when dma_req=1 and dma_ack=0, which limits the DMA to one access per two cycles.
REQ-020 The grant is combinational each cycle.
  - CPU wins if cpu_req=1 and force_dma=0.
  - Otherwise an eligible DMA request wins.
  - Otherwise no requester is granted.
REQ-021 On a CPU grant, mem_* SHALL carry the cpu_* fields, cpu_stall SHALL be 0 and grant_dma SHALL be 0.
REQ-022 On a DMA grant, mem_* SHALL carry the dma_* fields, grant_dma SHALL be 1 and cpu_stall SHALL equal cpu_req.
REQ-023 With no grant, mem_write SHALL be 0, mem_address SHALL equal cpu_addr and cpu_stall SHALL be 0.
REQ-024 cpu_rdata SHALL equal mem_read_data at all times.
REQ-025 On a DMA grant, dma_rdata SHALL register mem_read_data and dma_ack SHALL be 1 in the next cycle only.
  - Read latency is 1 cycle.
  - A DMA write commits at the end of the grant cycle.
REQ-026 dma_rdata SHALL hold its value until the next DMA grant.
REQ-027 The FSM SHALL have two states.
  - IDLE to ACK on a DMA grant.
  - ACK to IDLE unconditionally.
  - dma_ack=1 exactly in ACK.
REQ-028 A DMA request that is still held during ACK SHALL be treated as a new request from the following cycle onward.
REQ-029 When dma_req and cpu_req are asserted in the same cycle with force_dma=0, the CPU SHALL win and the DMA SHALL wait with no ack.

Reset
REQ-030 While reset=1, mem_write, dma_ack, grant_dma and cpu_stall SHALL be 0, irrespective of the request inputs.
REQ-031 At the clock edge with reset=1, the block SHALL enter state IDLE and clear the starvation counter, force_dma and dma_rdata to 0.
REQ-032 A DMA access that is in ACK when reset is asserted SHALL be dropped without an ack.

Configuration
REQ-033 The starvation guard SHALL be controlled by the macro DATA_MEM_ARBITER_STARVE_GUARD_EN.
REQ-034 With the macro defined:
  - A counter SHALL increment in each cycle with an eligible DMA request and a CPU grant.
  - The counter SHALL clear on any DMA grant or in any cycle with no eligible DMA request.
  - When the counter reaches STARVE_LIMIT, force_dma SHALL be 1 for the next cycle only and the counter SHALL clear.
REQ-035 With the macro undefined, the CPU SHALL have strict priority, force_dma SHALL be constant 0 and no counter SHALL exist.

Verification
REQ-036 CPU-only traffic: cpu_req=1, cpu_write=1, cpu_addr=0x0010, cpu_wdata=0xBEEF -> mem_write=1 with the CPU fields, cpu_stall=0, dma_ack never asserted.
REQ-037 DMA-only read: memory location 0x0020 holds 0x1234; dma_req=1, dma_addr=0x0020 for 1 cycle -> next cycle dma_ack=1 and dma_rdata=0x1234; dma_ack=0 in the cycle after.
REQ-038 Conflict: cpu_req=1 and dma_req=1 for 2 cycles, guard off -> CPU granted in both cycles, no DMA ack.
  - Then cpu_req drops -> DMA granted, ack 1 cycle later.
REQ-039 Starvation, macro defined, STARVE_LIMIT=4: cpu_req and dma_req held high -> CPU granted in cycles 0-3.
  - Cycle 4: DMA granted and cpu_stall=1.
  - Cycle 5: dma_ack=1 and the CPU is granted again.
REQ-040 Back-to-back DMA writes: dma_req held high with dma_write=1 -> mem_write pulses in alternate cycles only (grant, ack, grant).
REQ-041 Reset mid-operation: assert reset in the ACK cycle -> dma_ack=0 in that cycle, state IDLE afterwards, counter 0 and dma_rdata=0x0000.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-ported data memory between the CPU MEM stage and a
//   loader/DMA port. The grant is decided combinationally every cycle. The CPU
//   normally has priority. A DMA access completes with a one-cycle dma_ack
//   pulse and registered read data in the cycle after its grant.
//
//   Optional feature: define DATA_MEM_ARBITER_STARVE_GUARD_EN to enable the
//   starvation guard. When the DMA loses STARVE_LIMIT consecutive cycles to
//   the CPU, the guard forces a DMA grant for one cycle. When the macro is not
//   defined, the CPU has strict priority.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   cpu_req/write/byte_en        CPU MEM-stage request, store strobe, byte select
//   cpu_addr, cpu_wdata          CPU address and store data
//   cpu_rdata                    combinational read data (mirrors mem_read_data)
//   cpu_stall                    freezes the CPU pipeline while the DMA holds the memory
//   dma_req/write/byte_en        DMA request, store strobe, byte select
//   dma_addr, dma_wdata          DMA address and store data
//   dma_ack, dma_rdata           completion pulse and registered read data
//   mem_write/byte_en            data memory controls
//   mem_address, mem_write_data  data memory address and write data
//   mem_read_data                asynchronous read data from the data memory
//   grant_dma                    high in any cycle in which the DMA owns the memory
module data_mem_arbiter #(
  parameter int N            = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_write,
  input  logic         cpu_byte_en,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_wdata,
  output logic [N-1:0] cpu_rdata,
  output logic         cpu_stall,
  input  logic         dma_req,
  input  logic         dma_write,
  input  logic         dma_byte_en,
  input  logic [N-1:0] dma_addr,
  input  logic [N-1:0] dma_wdata,
  output logic         dma_ack,
  output logic [N-1:0] dma_rdata,
  output logic         mem_write,
  output logic         mem_byte_en,
  output logic [N-1:0] mem_address,
  output logic [N-1:0] mem_write_data,
  input  logic [N-1:0] mem_read_data,
  output logic         grant_dma
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] dma_rdata_q, dma_rdata_d;
  logic         force_dma;
  logic         dma_elig;
  logic         gnt_cpu;
  logic         gnt_dma;

  // dma_ack is masked by reset so that an access caught in ACK is dropped.
  assign dma_ack   = (state_q == ST_ACK) & ~reset;
  // A request seen during its own ack cycle is not a new request yet. This
  // limits the DMA to one access every two cycles.
  assign dma_elig  = dma_req & ~dma_ack;
  assign gnt_cpu   = ~reset & cpu_req & ~force_dma;
  assign gnt_dma   = ~reset & ~gnt_cpu & dma_elig;

  assign grant_dma = gnt_dma;
  assign cpu_stall = gnt_dma & cpu_req;
  assign cpu_rdata = mem_read_data;
  assign dma_rdata = dma_rdata_q;

  always_comb begin
    mem_write      = 1'b0;
    mem_byte_en    = cpu_byte_en;
    mem_address    = cpu_addr;
    mem_write_data = cpu_wdata;
    if (gnt_dma) begin
      mem_write      = dma_write;
      mem_byte_en    = dma_byte_en;
      mem_address    = dma_addr;
      mem_write_data = dma_wdata;
    end else if (gnt_cpu) begin
      mem_write      = cpu_write;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_dma) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
    endcase
  end

  assign dma_rdata_d = gnt_dma ? mem_read_data : dma_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

`ifdef DATA_MEM_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             force_q, force_d;

  // The counter counts consecutive cycles in which an eligible DMA request
  // loses to the CPU. When the count reaches the limit, the counter becomes a
  // one-cycle force pulse, and the counter restarts from zero.
  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    cnt_d   = '0;
    force_d = 1'b0;
    if (gnt_cpu && dma_elig) begin
      if (cnt_inc == CNT_W'(STARVE_LIMIT)) force_d = 1'b1;
      else                                 cnt_d   = cnt_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      force_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      force_q <= force_d;
    end
  end

  assign force_dma = force_q;
`else
  // Strict CPU priority. STARVE_LIMIT is never negative, so this
  // expression is a constant 0. It keeps the parameter in the interface.
  assign force_dma = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int N     = 16;
  localparam int LIMIT = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_write, cpu_byte_en;
  logic [N-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         dma_req, dma_write, dma_byte_en;
  logic [N-1:0] dma_addr, dma_wdata, dma_rdata;
  logic         dma_ack;
  logic         mem_write, mem_byte_en;
  logic [N-1:0] mem_address, mem_write_data, mem_read_data;
  logic         grant_dma;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] mem [0:255];

  data_mem_arbiter #(.N(N), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_byte_en(cpu_byte_en),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_write(dma_write), .dma_byte_en(dma_byte_en),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata),
    .mem_write(mem_write), .mem_byte_en(mem_byte_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .grant_dma(grant_dma)
  );

  always #5 clock = ~clock;

  // Data memory: asynchronous read, write committed at the clock edge
  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clock) if (mem_write) mem[mem_address[7:0]] <= mem_write_data;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  // Behavioural reference. ack_pending means "a DMA access was granted
  // last cycle". lost is the run of DMA cycles lost to the CPU.
  bit           m_ack_pending = 1'b0;
  int           m_lost        = 0;
  bit           m_force       = 1'b0;
  logic [N-1:0] m_rdata       = '0;

  always @(negedge clock) begin : model
    bit           ack_now, elig, cpu_wins, dma_wins;
    logic [N-1:0] e_addr, e_wdata;
    bit           e_we, e_be;
    ack_now  = m_ack_pending && !reset;
    elig     = dma_req && !ack_now;
    cpu_wins = !reset && cpu_req && !m_force;
    dma_wins = !reset && !cpu_wins && elig;
    if (dma_wins) begin
      e_addr = dma_addr; e_wdata = dma_wdata; e_we = dma_write; e_be = dma_byte_en;
    end else if (cpu_wins) begin
      e_addr = cpu_addr; e_wdata = cpu_wdata; e_we = cpu_write; e_be = cpu_byte_en;
    end else begin
      e_addr = cpu_addr; e_wdata = cpu_wdata; e_we = 1'b0; e_be = cpu_byte_en;
    end
    chk1 ("m_mem_write",   mem_write,   e_we);
    chk16("m_mem_address", mem_address, e_addr);
    chk1 ("m_grant_dma",   grant_dma,   dma_wins);
    chk1 ("m_cpu_stall",   cpu_stall,   dma_wins && cpu_req);
    chk1 ("m_dma_ack",     dma_ack,     ack_now);
    chk16("m_dma_rdata",   dma_rdata,   m_rdata);
    chk16("m_cpu_rdata",   cpu_rdata,   mem[e_addr[7:0]]);
    if (cpu_wins || dma_wins) begin
      chk16("m_mem_wdata", mem_write_data, e_wdata);
      chk1 ("m_mem_be",    mem_byte_en,    e_be);
    end
    // Advance the model to the state that follows the next rising edge.
    if (reset) begin
      m_ack_pending = 1'b0;
      m_lost        = 0;
      m_force       = 1'b0;
      m_rdata       = '0;
    end else begin
      m_ack_pending = dma_wins;
      if (dma_wins) m_rdata = mem[e_addr[7:0]];
`ifdef DATA_MEM_ARBITER_STARVE_GUARD_EN
      m_force = 1'b0;
      if (dma_wins || !elig) m_lost = 0;
      else if (cpu_wins) begin
        m_lost++;
        if (m_lost == LIMIT) begin
          m_force = 1'b1;
          m_lost  = 0;
        end
      end
`else
      m_force = 1'b0;
      m_lost  = 0;
`endif
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= N'(i * 7 + 16'h0100);
    mem[8'h20] <= 16'h1234;

    // Hold reset with every request asserted
    reset = 1'b1;
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_byte_en = 1'b1;
    cpu_addr = 16'h0011; cpu_wdata = 16'h5555;
    dma_req = 1'b1; dma_write = 1'b1; dma_byte_en = 1'b1;
    dma_addr = 16'h0022; dma_wdata = 16'hAAAA;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk1("rst_mem_write", mem_write, 1'b0);
      chk1("rst_dma_ack",   dma_ack,   1'b0);
      chk1("rst_grant_dma", grant_dma, 1'b0);
      chk1("rst_cpu_stall", cpu_stall, 1'b0);
      next_cyc();
    end
    reset = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; dma_req = 1'b0; dma_write = 1'b0;
    @(negedge clock);
    chk16("rst_dma_rdata", dma_rdata, 16'h0000);

    // CPU-only store
    next_cyc();
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    @(negedge clock);
    chk1 ("cpu_only_we",    mem_write,      1'b1);
    chk16("cpu_only_addr",  mem_address,    16'h0010);
    chk16("cpu_only_wdata", mem_write_data, 16'hBEEF);
    chk1 ("cpu_only_stall", cpu_stall,      1'b0);
    chk1 ("cpu_only_ack",   dma_ack,        1'b0);
    next_cyc();
    cpu_req = 1'b0; cpu_write = 1'b0;

    // DMA-only read of 0x0020
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0020;
    @(negedge clock);
    chk1("dma_rd_grant", grant_dma, 1'b1);
    chk1("dma_rd_we",    mem_write, 1'b0);
    next_cyc();
    dma_req = 1'b0;
    @(negedge clock);
    chk1 ("dma_rd_ack",   dma_ack,   1'b1);
    chk16("dma_rd_data",  dma_rdata, 16'h1234);
    next_cyc();
    @(negedge clock);
    chk1 ("dma_rd_ack_off", dma_ack,   1'b0);
    chk16("dma_rd_hold",    dma_rdata, 16'h1234);

    // Conflict for two cycles, after which the CPU drops its request
    next_cyc();
    cpu_req = 1'b1; cpu_addr = 16'h0030; dma_req = 1'b1; dma_addr = 16'h0040;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk1("conf_grant", grant_dma, 1'b0);
      chk1("conf_ack",   dma_ack,   1'b0);
      chk1("conf_stall", cpu_stall, 1'b0);
      next_cyc();
    end
    cpu_req = 1'b0;
    @(negedge clock);
    chk1("conf_dma_grant", grant_dma, 1'b1);
    next_cyc();
    dma_req = 1'b0;
    @(negedge clock);
    chk1("conf_dma_ack", dma_ack, 1'b1);

    // Both requests held high
    next_cyc();
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
`ifdef DATA_MEM_ARBITER_STARVE_GUARD_EN
      chk1("starve_grant", grant_dma, (c == 4));
      chk1("starve_stall", cpu_stall, (c == 4));
      chk1("starve_ack",   dma_ack,   (c == 5));
`else
      chk1("strict_grant", grant_dma, 1'b0);
      chk1("strict_ack",   dma_ack,   1'b0);
`endif
      next_cyc();
    end
    cpu_req = 1'b0; dma_req = 1'b0;

    // Back-to-back DMA writes: grant, ack, grant. Reset is asserted in the next ack cycle.
    next_cyc();
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0050; dma_wdata = 16'hA5A5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk1("b2b_we",    mem_write, (c != 1));
      chk1("b2b_grant", grant_dma, (c != 1));
      next_cyc();
    end
    reset = 1'b1;
    @(negedge clock);
    chk1("rst_ack_drop",  dma_ack,   1'b0);
    chk1("rst_ack_we",    mem_write, 1'b0);
    next_cyc();
    reset = 1'b0; dma_write = 1'b0;
    @(negedge clock);
    chk16("rst_mid_rdata", dma_rdata, 16'h0000);
    chk1 ("rst_mid_idle",  grant_dma, 1'b1);
    next_cyc();
    dma_req = 1'b0;
    @(negedge clock);
    chk1 ("post_rst_ack",   dma_ack,   1'b1);
    chk16("post_rst_rdata", dma_rdata, 16'hA5A5);

    // Randomized traffic checked by the model
    for (int c = 0; c < 1500; c++) begin
      next_cyc();
      reset       = ($urandom_range(0, 99) == 0);
      cpu_req     = ($urandom_range(0, 99) < 65);
      cpu_write   = $urandom_range(0, 1) == 1;
      cpu_byte_en = $urandom_range(0, 1) == 1;
      cpu_addr    = {8'h00, 8'($urandom_range(0, 255))};
      cpu_wdata   = 16'($urandom);
      dma_req     = ($urandom_range(0, 99) < 60);
      dma_write   = $urandom_range(0, 1) == 1;
      dma_byte_en = $urandom_range(0, 1) == 1;
      dma_addr    = {8'h00, 8'($urandom_range(0, 255))};
      dma_wdata   = 16'($urandom);
    end
    next_cyc();
    reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
